execute_cycle: RTL

- Execute stage of the 5-stage RISC-V pipeline. It consumes the ID/EX register contents produced by the decode stage and the forwarding selects produced by the hazard unit.
- Performs operand forwarding, ALU operation, branch/jump resolution and PC-target generation.
- Drives the EX/MEM pipeline register toward the memory stage.
- Returns branch_taken and PCSrcE to the fetch and decode stages for redirect and flush.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/alu.sv | 33 +++
 rtl/execute_cycle.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V pipeline: datapath width, ALU op codes,
// forwarding selects and result-select codes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback result selects
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   a, b    in  XLEN  operands
//   op      in  3     operation (add, sub, and, or, slt; other codes give 0)
//   result  out XLEN  operation result, add/sub wrap modulo 2^XLEN
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] result
);

    logic w_lt;

    assign w_lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU,
// beq/jal resolution, PC-target generation and the EX/MEM pipeline register.
// Optional macro EXEC_PERF_CNT_EN adds instr_cnt / redirect_cnt counters.
// Ports:
//   clk, rst                 stage clock, synchronous active-low reset
//   RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, RegWriteE, MemWriteE,
//   BranchE, JumpE, ALUSrcE, ResultWSrcE, ALUControlE   ID/EX contents
//   ForwardAE, ForwardBE, ResultW                        hazard unit / WB
//   PCTargetE, PCSrcE, branch_taken                      redirect to IF/ID
//   ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM,
//   MemWriteM, ResultWSrcM                               EX/MEM register
//   instr_cnt, redirect_cnt                              (EXEC_PERF_CNT_EN only)
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   RD1E,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   ImmExtE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic              ALUSrcE,
    input  logic [1:0]        ResultWSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              PCSrcE,
    output logic              branch_taken,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultWSrcM
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       redirect_cnt
`endif
);

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_write_data;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_result;

    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_write_data;
    logic [XLEN-1:0]   r_pc_plus4;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic              r_mem_write;
    logic [1:0]        r_result_src;

    // Forwarding: code 11 is unused and falls back to the register file value.
    always_comb begin
        w_src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_result;
            default: w_src_a = RD1E;
        endcase
    end

    always_comb begin
        w_write_data = RD2E;
        case (ForwardBE)
            FWD_WB:  w_write_data = ResultW;
            FWD_MEM: w_write_data = r_alu_result;
            default: w_write_data = RD2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a      (w_src_a),
        .b      (w_src_b),
        .op     (ALUControlE),
        .result (w_alu_result)
    );

    assign PCTargetE = PCE + ImmExtE;

    // Redirect outputs are held low while reset is asserted.
    assign branch_taken = rst & (w_alu_result == '0);
    assign PCSrcE       = rst & ((BranchE & branch_taken) | JumpE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 2'b00;
        end else begin
            r_alu_result <= w_alu_result;
            r_write_data <= w_write_data;
            r_pc_plus4   <= PCPlus4E;
            r_rd         <= RdE;
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultWSrcE;
        end
    end

    assign ALUResultM  = r_alu_result;
    assign WriteDataM  = r_write_data;
    assign PCPlus4M    = r_pc_plus4;
    assign RdM         = r_rd;
    assign RegWriteM   = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ResultWSrcM = r_result_src;

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] r_instr_cnt;
    logic [31:0] r_redirect_cnt;
    logic        w_valid_instr;

    // Any instruction with a side effect counts; decode bubbles have all controls low.
    assign w_valid_instr = RegWriteE | MemWriteE | BranchE | JumpE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_valid_instr) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
            if (PCSrcE) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign instr_cnt    = r_instr_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
